// File: rtl/axi_wdata_gen_if.sv
// axi_wdata_gen_if: descriptor, source word, AXI W/B and completion signals of the write-data stage.
// master is the write-data stage itself; slave is its environment.
interface axi_wdata_gen_if #(
    parameter int STRB_WIDTH = 32
);
    logic [8:0]              burst_words;
    logic                    burst_last;
    logic [STRB_WIDTH-1:0]   burst_head_strb;
    logic [STRB_WIDTH-1:0]   burst_tail_strb;
    logic                    burst_valid;
    logic                    burst_ready;
    logic [STRB_WIDTH*8-1:0] src_data;
    logic                    src_valid;
    logic                    src_ready;
    logic [STRB_WIDTH*8-1:0] axi_wdata;
    logic [STRB_WIDTH-1:0]   axi_wstrb;
    logic                    axi_wlast;
    logic                    axi_wvalid;
    logic                    axi_wready;
    logic [1:0]              axi_bresp;
    logic                    axi_bvalid;
    logic                    axi_bready;
    logic                    done;
    logic                    done_err;
    modport master (
        input  burst_words, burst_last, burst_head_strb, burst_tail_strb, burst_valid,
        input  src_data, src_valid, axi_wready, axi_bresp, axi_bvalid,
        output burst_ready, src_ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_bready, done, done_err
    );
    modport slave (
        output burst_words, burst_last, burst_head_strb, burst_tail_strb, burst_valid,
        output src_data, src_valid, axi_wready, axi_bresp, axi_bvalid,
        input  burst_ready, src_ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_bready, done, done_err
    );
endinterface

// File: rtl/axi_wdata_gen.sv
// axi_wdata_gen: drives AXI W beats from queued burst descriptors and source words,
// and reports per-request completion from the B responses.
module axi_wdata_gen #(
    parameter int STRB_WIDTH  = 32,
    parameter int DESC_DEPTH  = 4,
    parameter int OUTSTANDING = 8
) (
    input  logic            clk,
    input  logic            rstn,
    axi_wdata_gen_if.master bus
);
    localparam int DA = $clog2(DESC_DEPTH);
    localparam int RA = $clog2(OUTSTANDING);
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
    state_t                state_q, state_d;
    logic                  init_q;
    logic                  err_q, err_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic [STRB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [8:0]            dw_q [DESC_DEPTH];
    logic                  dl_q [DESC_DEPTH];
    logic [STRB_WIDTH-1:0] dh_q [DESC_DEPTH];
    logic [STRB_WIDTH-1:0] dt_q [DESC_DEPTH];
    logic [DA-1:0]         dwp_q, drp_q;
    logic [DA:0]           dcnt_q;
    logic                  rf_q [OUTSTANDING];
    logic [RA-1:0]         rwp_q, rrp_q;
    logic [RA:0]           rcnt_q;
    logic                  d_push, w_hs, w_end, b_hs, b_bad, wl, pop_flag;
    assign d_push   = bus.burst_valid && bus.burst_ready;
    assign wl       = state_q == DATA && cnt_q == 9'd1;
    assign w_hs     = state_q == DATA && bus.src_valid && bus.axi_wready;
    assign w_end    = w_hs && wl;
    assign b_hs     = bus.axi_bvalid && bus.axi_bready;
    assign b_bad    = bus.axi_bresp != 2'd0;
    assign pop_flag = rf_q[rrp_q];
    assign bus.burst_ready = init_q && dcnt_q < (DA+1)'(DESC_DEPTH);
    assign bus.axi_bready  = init_q && rcnt_q != '0;
    assign bus.axi_wdata   = bus.src_data;
    assign bus.done        = b_hs && pop_flag;
    assign bus.done_err    = bus.done && (err_q || b_bad);
    // A request's error is sticky across its bursts and cleared once its last response is seen.
    assign err_d = b_hs ? (err_q || b_bad) && !pop_flag : err_q;
    always_comb begin
        state_d        = IDLE;
        cnt_d          = cnt_q;
        first_d        = first_q;
        last_d         = last_q;
        head_d         = head_q;
        tail_d         = tail_q;
        bus.axi_wvalid = 1'b0;
        bus.src_ready  = 1'b0;
        bus.axi_wlast  = 1'b0;
        bus.axi_wstrb  = '0;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
                if (dcnt_q != '0 && rcnt_q != (RA+1)'(OUTSTANDING)) begin
                    state_d = DATA;
                    cnt_d   = dw_q[drp_q];
                    last_d  = dl_q[drp_q];
                    head_d  = dh_q[drp_q];
                    tail_d  = dt_q[drp_q];
                    first_d = 1'b1;
                end
            end
            DATA: begin
                bus.axi_wvalid = bus.src_valid;
                bus.src_ready  = bus.axi_wready;
                bus.axi_wlast  = wl;
                bus.axi_wstrb  = first_q && wl ? head_q & tail_q : first_q ? head_q : wl ? tail_q : '1;
                state_d        = w_end ? IDLE : DATA;
                if (w_hs) begin
                    cnt_d   = cnt_q - 9'd1;
                    first_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (d_push) begin
            dw_q[dwp_q] <= bus.burst_words;
            dl_q[dwp_q] <= bus.burst_last;
            dh_q[dwp_q] <= bus.burst_head_strb;
            dt_q[dwp_q] <= bus.burst_tail_strb;
        end
        if (w_end) rf_q[rwp_q] <= last_q;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            dwp_q   <= '0;
            drp_q   <= '0;
            dcnt_q  <= '0;
            rwp_q   <= '0;
            rrp_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            last_q  <= last_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            dwp_q   <= dwp_q + DA'(d_push);
            drp_q   <= drp_q + DA'(w_end);
            dcnt_q  <= dcnt_q + (DA+1)'(d_push) - (DA+1)'(w_end);
            rwp_q   <= rwp_q + RA'(w_end);
            rrp_q   <= rrp_q + RA'(b_hs);
            rcnt_q  <= rcnt_q + (RA+1)'(w_end) - (RA+1)'(b_hs);
        end
    end
endmodule

// File: tb/tb_axi_wdata_gen.sv
// tb_axi_wdata_gen: directed bench for axi_wdata_gen covering strobes, stalls,
// response-queue back-pressure, request error reporting and mid-burst reset.
module tb_axi_wdata_gen;
    localparam int SW = 32;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    int nbeat = 0;
    int nsrc = 0;
    logic [255:0] bd [$];
    logic [31:0]  bs [$];
    logic         bl [$];
    always #5 clk = ~clk;
    axi_wdata_gen_if #(.STRB_WIDTH(SW)) bus();
    axi_wdata_gen #(.STRB_WIDTH(SW), .DESC_DEPTH(4), .OUTSTANDING(8)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );
    // Handshakes recorded at the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.src_valid && bus.src_ready) nsrc++;
            if (bus.axi_wvalid && bus.axi_wready) begin
                bd.push_back(bus.axi_wdata);
                bs.push_back(bus.axi_wstrb);
                bl.push_back(bus.axi_wlast);
                nbeat++;
            end
            if (bus.burst_valid) begin
                n_chk++;
                assert (bus.burst_words != 9'd0) n_pass++;
                else $error("FAIL burst_words_zero: observed %0d required nonzero", bus.burst_words);
            end
        end
    end
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    function automatic logic [255:0] word(input int i);
        logic [31:0] w;
        w = 32'hA000_0000 + 32'(i);
        return {224'd0, w};
    endfunction
    task automatic push_desc(input int w, input bit l, input logic [31:0] h, input logic [31:0] t);
        int g = 0;
        bus.burst_words = 9'(w);
        bus.burst_last = l;
        bus.burst_head_strb = h;
        bus.burst_tail_strb = t;
        bus.burst_valid = 1'b1;
        #1;
        while (!bus.burst_ready && g < 300) begin
            cyc();
            g++;
        end
        chk("push_timeout", 256'(g < 300), 256'(1));
        cyc();
        bus.burst_valid = 1'b0;
    endtask
    task automatic run_beats(input int target, input bit rnd);
        int g = 0;
        while (nbeat < target && g < 4000) begin
            bus.src_valid = rnd ? $urandom_range(0, 2) != 0 : 1'b1;
            bus.axi_wready = rnd ? $urandom_range(0, 2) != 0 : 1'b1;
            bus.src_data = word(nsrc);
            cyc();
            g++;
        end
        bus.src_valid = 1'b0;
        bus.axi_wready = 1'b0;
        chk("beat_count", 256'(nbeat), 256'(target));
    endtask
    task automatic b_resp(input logic [1:0] r, input bit exp_done, input bit exp_err);
        bus.axi_bresp = r;
        bus.axi_bvalid = 1'b1;
        #1;
        chk("bready", 256'(bus.axi_bready), 256'(1));
        chk("done", 256'(bus.done), 256'(exp_done));
        chk("done_err", 256'(bus.done_err), 256'(exp_err));
        cyc();
        bus.axi_bvalid = 1'b0;
        bus.axi_bresp = 2'd0;
    endtask
    initial begin
        int b0;
        int errs;
        logic [31:0] es;
        bus.burst_words = 9'd1;
        bus.burst_last = 1'b0;
        bus.burst_head_strb = '0;
        bus.burst_tail_strb = '0;
        bus.burst_valid = 1'b0;
        bus.src_data = '0;
        bus.src_valid = 1'b0;
        bus.axi_wready = 1'b0;
        bus.axi_bresp = 2'd0;
        bus.axi_bvalid = 1'b0;
        cyc(3);
        chk("rst_burst_ready", 256'(bus.burst_ready), 256'(0));
        chk("rst_src_ready", 256'(bus.src_ready), 256'(0));
        chk("rst_wvalid", 256'(bus.axi_wvalid), 256'(0));
        chk("rst_wlast", 256'(bus.axi_wlast), 256'(0));
        chk("rst_wstrb", 256'(bus.axi_wstrb), 256'(0));
        chk("rst_bready", 256'(bus.axi_bready), 256'(0));
        chk("rst_done", 256'(bus.done), 256'(0));
        chk("rst_done_err", 256'(bus.done_err), 256'(0));
        rstn = 1'b1;
        #1;
        chk("init_ready_low", 256'(bus.burst_ready), 256'(0));
        cyc();
        chk("init_ready_high", 256'(bus.burst_ready), 256'(1));
        // single-beat burst: strobe is head & tail, first beat two cycles after the push
        bus.src_valid = 1'b1;
        bus.src_data = word(nsrc);
        push_desc(1, 1'b1, 32'hFFFF_FFF0, 32'h0000_00FF);
        chk("t1_lat_idle", 256'(bus.axi_wvalid), 256'(0));
        cyc();
        chk("t1_wvalid", 256'(bus.axi_wvalid), 256'(1));
        chk("t1_wstrb", 256'(bus.axi_wstrb), 256'h0000_00F0);
        chk("t1_wlast", 256'(bus.axi_wlast), 256'(1));
        chk("t1_wdata", bus.axi_wdata, word(0));
        cyc();
        chk("t1_wait_no_beat", 256'(nbeat), 256'(0));
        bus.axi_wready = 1'b1;
        cyc();
        bus.axi_wready = 1'b0;
        bus.src_valid = 1'b0;
        chk("t1_beats", 256'(nbeat), 256'(1));
        b_resp(2'd0, 1'b1, 1'b0);
        chk("t1_done_clear", 256'(bus.done), 256'(0));
        // four-beat burst strobe sequence
        push_desc(4, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
        run_beats(5, 1'b0);
        chk("t2_strb0", 256'(bs[1]), 256'hFFFF_0000);
        chk("t2_strb1", 256'(bs[2]), 256'hFFFF_FFFF);
        chk("t2_strb2", 256'(bs[3]), 256'hFFFF_FFFF);
        chk("t2_strb3", 256'(bs[4]), 256'h0000_FFFF);
        chk("t2_last", 256'({bl[1], bl[2], bl[3], bl[4]}), 256'b0001);
        b_resp(2'd0, 1'b1, 1'b0);
        // three bursts under random stalls on both sides
        push_desc(64, 1'b0, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        push_desc(64, 1'b0, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        push_desc(10, 1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        run_beats(5 + 138, 1'b1);
        errs = 0;
        for (int i = 0; i < 138 && 5 + i < nbeat; i++) begin
            es = (i == 0 || i == 64 || i == 128) ? 32'hFFFF_FFFC :
                 (i == 63 || i == 127 || i == 137) ? 32'h3FFF_FFFF : 32'hFFFF_FFFF;
            if (bd[5+i] !== word(5 + i)) errs++;
            if (bs[5+i] !== es) errs++;
            if (bl[5+i] !== (i == 63 || i == 127 || i == 137)) errs++;
        end
        chk("t3_stream_errors", 256'(errs), 256'(0));
        chk("t3_last_64", 256'(bl[5+63]), 256'(1));
        chk("t3_last_138", 256'(bl[5+137]), 256'(1));
        b_resp(2'd0, 1'b0, 1'b0);
        b_resp(2'd0, 1'b0, 1'b0);
        b_resp(2'd0, 1'b1, 1'b0);
        // response queue full: the ninth burst waits for the first B pop
        b0 = nbeat;
        bus.src_valid = 1'b1;
        bus.axi_wready = 1'b1;
        for (int i = 0; i < 9; i++) push_desc(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc(20);
        chk("t4_eight_beats", 256'(nbeat - b0), 256'(8));
        chk("t4_ninth_held", 256'(bus.axi_wvalid), 256'(0));
        b_resp(2'd0, 1'b1, 1'b0);
        chk("t4_idle_after_pop", 256'(bus.axi_wvalid), 256'(0));
        cyc();
        chk("t4_ninth_starts", 256'(bus.axi_wvalid), 256'(1));
        cyc();
        for (int i = 0; i < 8; i++) b_resp(2'd0, 1'b1, 1'b0);
        chk("t4_nine_beats", 256'(nbeat - b0), 256'(9));
        chk("t4_bready_drained", 256'(bus.axi_bready), 256'(0));
        bus.src_valid = 1'b0;
        bus.axi_wready = 1'b0;
        // error in the first burst of a two-burst request, then a clean request
        push_desc(2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push_desc(2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_beats(nbeat + 4, 1'b0);
        b_resp(2'd2, 1'b0, 1'b0);
        b_resp(2'd0, 1'b1, 1'b1);
        push_desc(3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_beats(nbeat + 3, 1'b0);
        b_resp(2'd0, 1'b1, 1'b0);
        // reset during beat 3 of an 8-beat burst
        b0 = nbeat;
        push_desc(8, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_beats(b0 + 2, 1'b0);
        bus.src_valid = 1'b1;
        bus.axi_wready = 1'b1;
        #1;
        chk("t6_beat3_presented", 256'(bus.axi_wvalid), 256'(1));
        rstn = 1'b0;
        cyc();
        chk("t6_wvalid_rst", 256'(bus.axi_wvalid), 256'(0));
        chk("t6_ready_rst", 256'(bus.burst_ready), 256'(0));
        chk("t6_wlast_rst", 256'(bus.axi_wlast), 256'(0));
        chk("t6_bready_rst", 256'(bus.axi_bready), 256'(0));
        cyc();
        rstn = 1'b1;
        #1;
        chk("t6_ready_release", 256'(bus.burst_ready), 256'(0));
        cyc();
        chk("t6_ready_back", 256'(bus.burst_ready), 256'(1));
        cyc(3);
        chk("t6_no_beat_after", 256'(bus.axi_wvalid), 256'(0));
        chk("t6_beats", 256'(nbeat), 256'(b0 + 2));
        bus.src_valid = 1'b0;
        bus.axi_wready = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
